seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Time-multiplexed seven-segment scan driver sitting directly downstream of the per-digit display PIOs on the platform bus. Takes NUM_DIGITS 7-bit segment patterns in parallel, one per PIO `out_port`, and drives them onto a shared segment bus with one-hot digit enables. Inserts a blanking gap between digits to suppress ghosting, and latches each pattern per slot so software writes never tear a lit digit.

## Interface
- `NUM_DIGITS`, 4: digits scanned; range 2..8.
- `SCAN_DIV`, 50000: clk cycles per digit slot, blank plus show; must be greater than `BLANK_CYCLES`.
- `BLANK_CYCLES`, 500: cycles of the slot with all digits off; must be at least 1.
- `ACTIVE_LOW`, 1: 1 means segment and digit outputs are active-low; 0 means active-high.

- `clk`  in  1  single clock domain; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  scan run; low forces the display dark.
- `seg_in`  in  7*NUM_DIGITS  segment patterns; digit k on bits [7k+6:7k]; bit 0 is segment a, bit 6 is segment g; a 1 means lit.
- `seg_out`  out  7  shared segment bus, polarity set by ACTIVE_LOW.
- `dig_out`  out  NUM_DIGITS  digit enables, one-hot active in SHOW, polarity set by ACTIVE_LOW.
- `frame_tick`  out  1  one-cycle pulse at the end of the last digit's slot.

## Operation
- State machine states: OFF, BLANK, SHOW. Registers: slot counter `cnt` (clog2(SCAN_DIV) bits), digit index `idx`, latched pattern `seg_q`.
- Reset: state OFF, cnt 0, idx 0, seg_q 0. All outputs are inactive: with ACTIVE_LOW=1, seg_out = 7'h7F and dig_out all ones. frame_tick = 0.
- OFF: outputs inactive. When `enable` = 1, go to BLANK with cnt 0 and idx 0.
- BLANK: outputs inactive. cnt counts 0..BLANK_CYCLES-1. At BLANK_CYCLES-1:
  - latch seg_q from the idx field of seg_in;
  - go to SHOW with cnt 0.
- SHOW:
  - seg_out shows seg_q, inverted when ACTIVE_LOW;
  - dig_out is one-hot on idx;
  - cnt counts 0..SCAN_DIV-BLANK_CYCLES-1.
- End of SHOW: go to BLANK with cnt 0 and advance idx.
  - idx wraps from NUM_DIGITS-1 to 0.
  - On the wrap, frame_tick = 1 for exactly one cycle.
- seg_in is sampled only at the BLANK-to-SHOW edge. Changes during SHOW or BLANK take effect in that digit's next slot.
- `enable` = 0 in BLANK or SHOW: on the next edge, state OFF, idx 0, cnt 0, outputs inactive, and no frame_tick.
- Reset asserted in any state forces reset values immediately, without waiting for a clock edge. Deassertion resumes in OFF.
- No digit is ever active in BLANK or OFF. At most one dig_out bit is ever active.

## Timing
- All outputs are registered and update on the same edge as the state register. There is no combinational path from inputs to outputs.
- enable low to high: the first SHOW cycle comes BLANK_CYCLES+1 edges after `enable` is first sampled high. That is 1 edge to leave OFF, then BLANK_CYCLES in BLANK.
- Slot length is exactly SCAN_DIV cycles. Frame length is NUM_DIGITS*SCAN_DIV cycles. frame_tick period equals the frame length.
- enable high to low: outputs go inactive at the first edge that samples `enable` = 0.

## Configuration
- `SEG_SCAN_BLINK_EN` defined:
  - adds input `blink_mask` [NUM_DIGITS-1:0] and parameter `BLINK_FRAMES` (default 64);
  - a frame counter toggles a blink phase every BLINK_FRAMES frame_ticks; the phase is 0 after reset and after OFF;
  - during the phase-1 half, a digit whose mask bit is set keeps its SHOW slot timing, but its dig_out and seg_out stay inactive.
- `SEG_SCAN_BLINK_EN` undefined: no blink_mask port, no frame counter, no phase logic. Behaviour is exactly as described above.

## Test plan
Common setup: NUM_DIGITS=4, SCAN_DIV=10, BLANK_CYCLES=2, ACTIVE_LOW=1.

- **Reset hold:** reset=1, enable=1 → seg_out=7'h7F, dig_out=4'hF, frame_tick=0 throughout; released in OFF.
- **Basic scan:** seg_in={7'h06,7'h5B,7'h4F,7'h66}, enable rises → 3 edges later seg_out=7'h19 and dig_out=4'b1110 for 8 cycles, then 2 dark cycles, then 7'h30 / 4'b1101. frame_tick pulses once every 40 cycles.
- **No tearing:** change digit-0 field to 7'h3F at the 3rd cycle of digit 0's SHOW → seg_out holds 7'h19 until slot end; the next digit-0 slot shows 7'h40.
- **Enable drop:** enable=0 in digit 2 SHOW → next edge seg_out=7'h7F, dig_out=4'hF, no frame_tick. Re-enable → restarts at digit 0 after 3 edges.
- **Async reset mid-frame:** pulse reset between clock edges during SHOW → outputs go inactive before the next edge; the scan restarts from OFF.
- **Blink (macro defined):** BLINK_FRAMES=2, blink_mask=4'b0001 → digit 0 is dark for frames 2-3, lit for frames 4-5; the other digits are unaffected.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver: blank gap, then one latched digit per slot.
// Optional blink support is compiled in with `define SEG_SCAN_BLINK_EN.
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter bit ACTIVE_LOW   = 1'b1
`ifdef SEG_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [7*NUM_DIGITS-1:0] seg_in,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_out,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]      SHOW_LAST  = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF    = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [NUM_DIGITS-1:0] DIG_ONE    = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [IDX_W-1:0]        idx, idx_n;
    logic [6:0]              seg_q, seg_q_n;
    logic                    tick_n;
    logic [6:0]              seg_o_n;
    logic [NUM_DIGITS-1:0]   dig_o_n;
    logic                    blank_digit;
    logic [6:0]              field [NUM_DIGITS];

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_field
        assign field[k] = seg_in[7*k +: 7];
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        seg_q_n = seg_q;
        tick_n  = 1'b0;
        unique case (state)
            ST_OFF: begin
                if (enable) begin
                    state_n = ST_BLANK;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            end
            ST_BLANK: begin
                if (!enable) begin
                    state_n = ST_OFF;
                    cnt_n   = '0;
                    idx_n   = '0;
                end else if (cnt == BLANK_LAST) begin
                    // Pattern is captured once per slot so a lit digit never tears.
                    state_n = ST_SHOW;
                    cnt_n   = '0;
                    seg_q_n = field[idx];
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_SHOW: begin
                if (!enable) begin
                    state_n = ST_OFF;
                    cnt_n   = '0;
                    idx_n   = '0;
                end else if (cnt == SHOW_LAST) begin
                    state_n = ST_BLANK;
                    cnt_n   = '0;
                    if (idx == IDX_LAST) begin
                        idx_n  = '0;
                        tick_n = 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_OFF;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] frame_cnt, frame_cnt_n;
    logic            phase, phase_n;

    always_comb begin
        frame_cnt_n = frame_cnt;
        phase_n     = phase;
        if (state_n == ST_OFF) begin
            frame_cnt_n = '0;
            phase_n     = 1'b0;
        end else if (tick_n) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt_n = '0;
                phase_n     = ~phase;
            end else begin
                frame_cnt_n = frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            frame_cnt <= frame_cnt_n;
            phase     <= phase_n;
        end
    end

    assign blank_digit = phase_n & blink_mask[idx_n];
`else
    assign blank_digit = 1'b0;
`endif

    // Outputs are computed from next state so they change on the same edge as the FSM.
    always_comb begin
        seg_o_n = SEG_OFF;
        dig_o_n = DIG_OFF;
        if (state_n == ST_SHOW && !blank_digit) begin
            seg_o_n = ACTIVE_LOW ? ~seg_q_n : seg_q_n;
            dig_o_n = ACTIVE_LOW ? ~(DIG_ONE << idx_n) : (DIG_ONE << idx_n);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_OFF;
            cnt        <= '0;
            idx        <= '0;
            seg_q      <= '0;
            seg_out    <= SEG_OFF;
            dig_out    <= DIG_OFF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            seg_q      <= seg_q_n;
            seg_out    <= seg_o_n;
            dig_out    <= dig_o_n;
            frame_tick <= tick_n;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random patterns/enable drops vs a timeline model.
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int SD = 10;
    localparam int BC = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [7*ND-1:0] seg_in;
    logic [6:0]      seg_out;
    logic [ND-1:0]   dig_out;
    logic            frame_tick;

    int n_vec = 0;
    int n_err = 0;

    // Model: m_p counts cycles since the scan left OFF; everything else follows arithmetically.
    bit         m_run = 1'b0;
    int         m_p   = 0;
    logic [6:0] m_lat = 7'h00;

    int cyc_n     = 0;
    int last_tick = -1;

    seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .BLANK_CYCLES(BC),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .seg_in    (seg_in),
        .seg_out   (seg_out),
        .dig_out   (dig_out),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run <= 1'b0;
            m_p   <= 0;
        end else if (!enable) begin
            m_run <= 1'b0;
            m_p   <= 0;
        end else if (!m_run) begin
            m_run <= 1'b1;
            m_p   <= 0;
        end else begin
            m_p <= m_p + 1;
            if (((m_p + 1) % SD) == BC)
                m_lat <= seg_in[7*(((m_p + 1) / SD) % ND) +: 7];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        int            d;
        bit            show;
        logic [6:0]    e_seg;
        logic [ND-1:0] e_dig;
        bit            e_tick;
        @(negedge clk);
        cyc_n++;
        d      = (m_p / SD) % ND;
        show   = m_run && ((m_p % SD) >= BC);
        e_seg  = show ? ~m_lat : 7'h7F;
        e_dig  = show ? ~(ND'(1) << d) : {ND{1'b1}};
        e_tick = m_run && (m_p > 0) && ((m_p % SD) == 0) && (d == 0);
        check_eq("seg_out", 32'(seg_out), 32'(e_seg));
        check_eq("dig_out", 32'(dig_out), 32'(e_dig));
        check_eq("frame_tick", 32'(frame_tick), 32'(e_tick));
        check_eq("dig_onehot", 32'($countones(~dig_out) <= 1), 32'd1);
        if (!m_run) last_tick = -1;
        if (frame_tick) begin
            if (last_tick >= 0)
                check_eq("tick_period", 32'(cyc_n - last_tick), 32'(ND * SD));
            last_tick = cyc_n;
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        seg_in = {7'h06, 7'h5B, 7'h4F, 7'h66};

        repeat (4) cyc();
        check_eq("rst_seg", 32'(seg_out), 32'h7F);
        check_eq("rst_dig", 32'(dig_out), 32'hF);
        check_eq("rst_tick", 32'(frame_tick), 32'h0);
        reset = 1'b0;

        repeat (3) cyc();
        check_eq("first_show_seg", 32'(seg_out), 32'h19);
        check_eq("first_show_dig", 32'(dig_out), 32'hE);

        repeat (2) cyc();
        seg_in[6:0] = 7'h3F;
        repeat (5) cyc();
        check_eq("no_tear_seg", 32'(seg_out), 32'h19);
        cyc();
        check_eq("gap_seg", 32'(seg_out), 32'h7F);
        check_eq("gap_dig", 32'(dig_out), 32'hF);
        repeat (2) cyc();
        check_eq("d1_seg", 32'(seg_out), 32'h30);
        check_eq("d1_dig", 32'(dig_out), 32'hD);
        repeat (30) cyc();
        check_eq("d0_new_seg", 32'(seg_out), 32'h40);
        check_eq("d0_new_dig", 32'(dig_out), 32'hE);

        repeat (23) cyc();
        enable = 1'b0;
        cyc();
        check_eq("drop_seg", 32'(seg_out), 32'h7F);
        check_eq("drop_dig", 32'(dig_out), 32'hF);
        check_eq("drop_tick", 32'(frame_tick), 32'h0);
        repeat (2) cyc();
        enable = 1'b1;
        repeat (3) cyc();
        check_eq("reen_seg", 32'(seg_out), 32'h40);
        check_eq("reen_dig", 32'(dig_out), 32'hE);

        #2 reset = 1'b1;
        #1;
        check_eq("areset_seg", 32'(seg_out), 32'h7F);
        check_eq("areset_dig", 32'(dig_out), 32'hF);
        check_eq("areset_tick", 32'(frame_tick), 32'h0);
        reset = 1'b0;
        repeat (3) cyc();
        check_eq("after_areset_seg", 32'(seg_out), 32'h40);

        repeat (130) cyc();

        for (int i = 0; i < 800; i++) begin
            cyc();
            if ($urandom_range(0, 3) == 0) begin
                int k;
                k = int'($urandom_range(0, ND - 1));
                seg_in[7*k +: 7] = 7'($urandom);
            end
            if (enable && $urandom_range(0, 149) == 0)
                enable = 1'b0;
            else if (!enable && $urandom_range(0, 1) == 0)
                enable = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
